// File: rtl/spi_accel_responder.sv
// SPI mode-0 responder emulating a three-axis accelerometer: cmd, addr, then auto-incrementing burst data.
// Pins sync'd through 2 FFs; internal action 3 clocks after a pin edge, miso valid 3-4 clocks after sclk fall.
module spi_accel_responder #(
   parameter logic [7:0] DEVID_AD  = 8'hAD,
   parameter logic [7:0] DEVID_MST = 8'h1D,
   parameter logic [7:0] PARTID    = 8'hF2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sclk,
   input  logic               mosi,
   input  logic               ss,
   output logic               miso,
   input  logic signed [11:0] sample_x,
   input  logic signed [11:0] sample_y,
   input  logic signed [11:0] sample_z,
   output logic [7:0]         power_ctl,
   output logic               busy,
   output logic               cmd_err
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGNORE} state_t;

   logic [2:0]  sclk_sync_q, ss_sync_q;
   logic [1:0]  mosi_sync_q;
   logic        armed_q;
   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        is_wr_q, is_wr_d;
   logic [7:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic        load_q, load_d;
   logic        reload_q, reload_d;
   logic        cmd_err_q, cmd_err_d;
   logic [7:0]  power_q, power_d;
   logic [7:0]  scratch_q [0:12];
   logic [7:0]  scratch_d [0:12];
   logic [11:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;

   logic        sclk_rise, sclk_fall, ss_rise, ss_fall, last_bit, scratch_hit;
   logic [7:0]  byte_in, rd_dat;

   assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
   assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
   assign byte_in     = {shift_q[6:0], mosi_sync_q[1]};
   assign last_bit    = (bit_cnt_q == 3'd7);
   assign scratch_hit = (ptr_q[7:4] == 4'h2) && (ptr_q[3:0] <= 4'hC);

   assign miso      = miso_q;
   assign power_ctl = power_q;
   assign cmd_err   = cmd_err_q;
   // The ss chain resets "low" and armed_q gates busy, so a select held low
   // across reset release is not mistaken for a fresh transaction.
   assign busy      = armed_q & ~ss_sync_q[1];

   always_comb begin
      rd_dat = 8'h00;
      case (ptr_q)
         8'h00:   rd_dat = DEVID_AD;
         8'h01:   rd_dat = DEVID_MST;
         8'h02:   rd_dat = PARTID;
         8'h08:   rd_dat = shx_q[11:4];
         8'h09:   rd_dat = shy_q[11:4];
         8'h0A:   rd_dat = shz_q[11:4];
         8'h0E:   rd_dat = shx_q[7:0];
         8'h0F:   rd_dat = {{4{shx_q[11]}}, shx_q[11:8]};
         8'h10:   rd_dat = shy_q[7:0];
         8'h11:   rd_dat = {{4{shy_q[11]}}, shy_q[11:8]};
         8'h12:   rd_dat = shz_q[7:0];
         8'h13:   rd_dat = {{4{shz_q[11]}}, shz_q[11:8]};
         8'h2D:   rd_dat = power_q;
         default: if (scratch_hit) rd_dat = scratch_q[ptr_q[3:0]];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      is_wr_d   = is_wr_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      load_d    = 1'b0;
      reload_d  = reload_q;
      cmd_err_d = 1'b0;
      power_d   = power_q;
      scratch_d = scratch_q;
      shx_d     = shx_q;
      shy_d     = shy_q;
      shz_d     = shz_q;

      if (ss_rise) begin
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
         miso_d    = 1'b0;
         reload_d  = 1'b0;
      end else if (ss_fall) begin
         state_d   = S_CMD;
         bit_cnt_d = 3'd0;
         miso_d    = 1'b0;
         reload_d  = 1'b0;
         shx_d     = sample_x;
         shy_d     = sample_y;
         shz_d     = sample_z;
      end else begin
         if (load_q) begin
            tx_d   = rd_dat;
            miso_d = rd_dat[7];
         end
         if (sclk_rise && state_q != S_IDLE && state_q != S_IGNORE) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         case (state_q)
            S_CMD: if (sclk_rise && last_bit) begin
               if (byte_in == 8'h0B || byte_in == 8'h0A) begin
                  state_d = S_ADDR;
                  is_wr_d = (byte_in == 8'h0A);
               end else begin
                  state_d   = S_IGNORE;
                  cmd_err_d = 1'b1;
               end
            end
            S_ADDR: if (sclk_rise && last_bit) begin
               ptr_d = byte_in;
               if (is_wr_q) begin
                  state_d = S_WR;
               end else begin
                  // Load once the pointer settles; the following fall reloads the same byte.
                  state_d  = S_RD;
                  load_d   = 1'b1;
                  reload_d = 1'b1;
               end
            end
            S_RD: begin
               if (sclk_rise && last_bit) begin
                  ptr_d    = ptr_q + 8'd1;
                  reload_d = 1'b1;
               end
               if (sclk_fall) begin
                  if (reload_q) begin
                     tx_d     = rd_dat;
                     miso_d   = rd_dat[7];
                     reload_d = 1'b0;
                  end else begin
                     tx_d   = {tx_q[6:0], 1'b0};
                     miso_d = tx_q[6];
                  end
               end
            end
            S_WR: if (sclk_rise && last_bit) begin
               if (scratch_hit) scratch_d[ptr_q[3:0]] = byte_in;
               if (ptr_q == 8'h2D) power_d = byte_in;
               ptr_d = ptr_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclk_sync_q <= 3'b000;
         ss_sync_q   <= 3'b000;
         mosi_sync_q <= 2'b00;
         armed_q     <= 1'b0;
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         ptr_q       <= 8'h00;
         is_wr_q     <= 1'b0;
         tx_q        <= 8'h00;
         miso_q      <= 1'b0;
         load_q      <= 1'b0;
         reload_q    <= 1'b0;
         cmd_err_q   <= 1'b0;
         power_q     <= 8'h00;
         for (int i = 0; i < 13; i++) scratch_q[i] <= 8'h00;
         shx_q       <= 12'h000;
         shy_q       <= 12'h000;
         shz_q       <= 12'h000;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], sclk};
         ss_sync_q   <= {ss_sync_q[1:0], ss};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         armed_q     <= armed_q | ss_sync_q[1];
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         is_wr_q     <= is_wr_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         load_q      <= load_d;
         reload_q    <= reload_d;
         cmd_err_q   <= cmd_err_d;
         power_q     <= power_d;
         scratch_q   <= scratch_d;
         shx_q       <= shx_d;
         shy_q       <= shy_d;
         shz_q       <= shz_d;
      end
   end
endmodule
